// File: rtl/svc_fb_rd_arbiter_if.sv
// One AXI read channel pair (AR + R); master drives AR and rready, slave drives arready and R.
// Used for both requester ports and the shared memory port of svc_fb_rd_arbiter.
interface svc_fb_rd_arbiter_if #(
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 4
);
    logic                      arvalid;
    logic                      arready;
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic [AXI_ID_WIDTH-1:0]   arid;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;

    logic                      rvalid;
    logic                      rready;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [AXI_ID_WIDTH-1:0]   rid;
    logic [1:0]                rresp;
    logic                      rlast;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rid, rresp, rlast,
        output rready
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rid, rresp, rlast,
        input  rready
    );
endinterface

// File: rtl/svc_fb_rd_arbiter.sv
// Two-requester AXI read arbiter sharing one framebuffer read port; s0 (scan-out) has priority,
// s1 is forced after STARVE_LIMIT consecutive s0 wins. One burst in flight, grant held to rlast.
module svc_fb_rd_arbiter #(
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    svc_fb_rd_arbiter_if.slave         s0_axi,
    svc_fb_rd_arbiter_if.slave         s1_axi,
    svc_fb_rd_arbiter_if.master        m_axi,
    output logic                       grant,
    output logic                       busy
);

    localparam logic [7:0] LP_LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic                      r_gnt;
    logic [7:0]                r_starve;

    logic                      r_m_arvalid;
    logic [AXI_ADDR_WIDTH-1:0] r_m_araddr;
    logic [AXI_ID_WIDTH-1:0]   r_m_arid;
    logic [7:0]                r_m_arlen;
    logic [2:0]                r_m_arsize;
    logic [1:0]                r_m_arburst;

    logic                      w_pick0;
    logic                      w_pick1;
    logic                      w_accept;
    logic                      w_s0_arready;
    logic                      w_s1_arready;
    logic                      w_m_rready;
    logic                      w_s0_rvalid;
    logic                      w_s1_rvalid;

    logic [AXI_ADDR_WIDTH-1:0] w_ar_addr;
    logic [AXI_ID_WIDTH-1:0]   w_ar_id;
    logic [7:0]                w_ar_len;
    logic [2:0]                w_ar_size;
    logic [1:0]                w_ar_burst;

    logic [AXI_DATA_WIDTH-1:0] w_rdata;
    logic [AXI_ID_WIDTH-1:0]   w_rid;
    logic [1:0]                w_rresp;
    logic                      w_rlast;

    // Gating with rst keeps both arready outputs low while reset is held.
    always_comb begin
        w_pick1 = !rst && s1_axi.arvalid && (!s0_axi.arvalid || (r_starve >= LP_LIMIT));
        w_pick0 = !rst && s0_axi.arvalid && !w_pick1;
    end

    always_comb begin
        if (w_pick1) begin
            w_ar_addr  = s1_axi.araddr;
            w_ar_id    = s1_axi.arid;
            w_ar_len   = s1_axi.arlen;
            w_ar_size  = s1_axi.arsize;
            w_ar_burst = s1_axi.arburst;
        end else begin
            w_ar_addr  = s0_axi.araddr;
            w_ar_id    = s0_axi.arid;
            w_ar_len   = s0_axi.arlen;
            w_ar_size  = s0_axi.arsize;
            w_ar_burst = s0_axi.arburst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_s0_arready = 1'b0;
        w_s1_arready = 1'b0;
        w_m_rready   = 1'b0;
        w_s0_rvalid  = 1'b0;
        w_s1_rvalid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_s0_arready = w_pick0;
                w_s1_arready = w_pick1;
                if (w_pick0 || w_pick1) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_axi.arready) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                // Only the owner sees R beats; its rready alone throttles the memory.
                w_m_rready  = r_gnt ? s1_axi.rready : s0_axi.rready;
                w_s0_rvalid = !r_gnt && m_axi.rvalid;
                w_s1_rvalid = r_gnt && m_axi.rvalid;
                if (m_axi.rvalid && w_m_rready && m_axi.rlast) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt       <= 1'b0;
            r_starve    <= 8'd0;
            r_m_arvalid <= 1'b0;
            r_m_araddr  <= '0;
            r_m_arid    <= '0;
            r_m_arlen   <= 8'd0;
            r_m_arsize  <= 3'd0;
            r_m_arburst <= 2'd0;
        end else if (w_accept) begin
            r_gnt       <= w_pick1;
            r_m_arvalid <= 1'b1;
            r_m_araddr  <= w_ar_addr;
            r_m_arid    <= w_ar_id;
            r_m_arlen   <= w_ar_len;
            r_m_arsize  <= w_ar_size;
            r_m_arburst <= w_ar_burst;
            if (w_pick1) begin
                r_starve <= 8'd0;
            end else if (s1_axi.arvalid && (r_starve != 8'hFF)) begin
                r_starve <= r_starve + 8'd1;
            end
        end else if ((r_state == ST_ADDR) && m_axi.arready) begin
            r_m_arvalid <= 1'b0;
        end
    end

    assign m_axi.arvalid = r_m_arvalid;
    assign m_axi.araddr  = r_m_araddr;
    assign m_axi.arid    = r_m_arid;
    assign m_axi.arlen   = r_m_arlen;
    assign m_axi.arsize  = r_m_arsize;
    assign m_axi.arburst = r_m_arburst;
    assign m_axi.rready  = w_m_rready;

    assign s0_axi.arready = w_s0_arready;
    assign s1_axi.arready = w_s1_arready;
    assign s0_axi.rvalid  = w_s0_rvalid;
    assign s1_axi.rvalid  = w_s1_rvalid;

    // R payload is broadcast; rvalid alone tells each requester whether the beat is theirs.
    assign w_rdata = m_axi.rdata;
    assign w_rid   = m_axi.rid;
    assign w_rresp = m_axi.rresp;
    assign w_rlast = m_axi.rlast;

    assign s0_axi.rdata = w_rdata;
    assign s0_axi.rid   = w_rid;
    assign s0_axi.rresp = w_rresp;
    assign s0_axi.rlast = w_rlast;
    assign s1_axi.rdata = w_rdata;
    assign s1_axi.rid   = w_rid;
    assign s1_axi.rresp = w_rresp;
    assign s1_axi.rlast = w_rlast;

    assign grant = r_gnt;
    assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_svc_fb_rd_arbiter.sv
// Directed bench for svc_fb_rd_arbiter: drives at negedge, samples 1ns later.
module tb_svc_fb_rd_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic grant;
    logic busy;

    always #5 clk = ~clk;

    svc_fb_rd_arbiter_if #(.AXI_ADDR_WIDTH(16), .AXI_DATA_WIDTH(16), .AXI_ID_WIDTH(4)) s0_if ();
    svc_fb_rd_arbiter_if #(.AXI_ADDR_WIDTH(16), .AXI_DATA_WIDTH(16), .AXI_ID_WIDTH(4)) s1_if ();
    svc_fb_rd_arbiter_if #(.AXI_ADDR_WIDTH(16), .AXI_DATA_WIDTH(16), .AXI_ID_WIDTH(4)) m_if ();

    svc_fb_rd_arbiter #(
        .AXI_ADDR_WIDTH(16),
        .AXI_DATA_WIDTH(16),
        .AXI_ID_WIDTH  (4),
        .STARVE_LIMIT  (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .s0_axi(s0_if.slave),
        .s1_axi(s1_if.slave),
        .m_axi (m_if.master),
        .grant (grant),
        .busy  (busy)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] q_data[$];
    logic [1:0]  q_resp[$];
    logic        q_last[$];
    logic [3:0]  q_id[$];
    int          mirror_bad;
    int          stray_bad;

    task automatic issue(input bit who, input logic [15:0] addr, input logic [3:0] id,
                         input logic [7:0] len, output int wait_cyc);
        if (who) begin
            s1_if.araddr = addr; s1_if.arid = id; s1_if.arlen = len;
            s1_if.arsize = 3'd1; s1_if.arburst = 2'd1; s1_if.arvalid = 1'b1;
        end else begin
            s0_if.araddr = addr; s0_if.arid = id; s0_if.arlen = len;
            s0_if.arsize = 3'd1; s0_if.arburst = 2'd1; s0_if.arvalid = 1'b1;
        end
        wait_cyc = 0;
        #1;
        while (!(who ? s1_if.arready : s0_if.arready) && wait_cyc < 20) begin
            @(negedge clk); #1;
            wait_cyc++;
        end
        @(negedge clk);
        if (who) s1_if.arvalid = 1'b0;
        else     s0_if.arvalid = 1'b0;
    endtask

    task automatic mem_ar_accept(output bit seen);
        m_if.arready = 1'b1;
        #1;
        seen = m_if.arvalid;
        @(negedge clk);
        m_if.arready = 1'b0;
    endtask

    task automatic mem_burst(input bit who, input int n, input logic [15:0] base,
                             input logic [3:0] id, input int err_beat, input bit toggle,
                             output bit timed_out);
        int  k   = 0;
        int  cyc = 0;
        logic rr;
        q_data.delete(); q_resp.delete(); q_last.delete(); q_id.delete();
        mirror_bad = 0;
        stray_bad  = 0;
        while (k < n && cyc < 100) begin
            m_if.rvalid = 1'b1;
            m_if.rdata  = base + 16'(k);
            m_if.rid    = id;
            m_if.rresp  = (k == err_beat) ? 2'b10 : 2'b00;
            m_if.rlast  = (k == n - 1);
            rr = toggle ? ~cyc[0] : 1'b1;
            if (who) begin s1_if.rready = rr; s0_if.rready = 1'b1; end
            else     begin s0_if.rready = rr; s1_if.rready = 1'b1; end
            #1;
            if (m_if.rready !== rr) mirror_bad++;
            if ((who ? s0_if.rvalid : s1_if.rvalid) !== 1'b0) stray_bad++;
            if ((who ? s1_if.rvalid : s0_if.rvalid) && rr) begin
                q_data.push_back(who ? s1_if.rdata : s0_if.rdata);
                q_resp.push_back(who ? s1_if.rresp : s0_if.rresp);
                q_last.push_back(who ? s1_if.rlast : s0_if.rlast);
                q_id.push_back(who ? s1_if.rid : s0_if.rid);
            end
            if (m_if.rvalid && m_if.rready) k++;
            @(negedge clk);
            cyc++;
        end
        m_if.rvalid = 1'b0;
        m_if.rlast  = 1'b0;
        m_if.rresp  = 2'b00;
        timed_out = (k < n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s0_if.arvalid = 1'b1; s1_if.arvalid = 1'b1;
        m_if.rvalid = 1'b1; s0_if.rready = 1'b1; s1_if.rready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
        total++; if (grant !== 1'b0) begin bad++; $display("FAIL rst_grant got %b want 0", grant); end
        total++; if (m_if.arvalid !== 1'b0) begin bad++; $display("FAIL rst_m_arvalid got %b want 0", m_if.arvalid); end
        total++; if ({m_if.araddr, m_if.arid, m_if.arlen} !== 28'h0) begin bad++; $display("FAIL rst_ar_payload got %h want 0", {m_if.araddr, m_if.arid, m_if.arlen}); end
        total++; if ({s0_if.arready, s1_if.arready} !== 2'b00) begin bad++; $display("FAIL rst_arready got %b want 00", {s0_if.arready, s1_if.arready}); end
        total++; if ({m_if.rready, s0_if.rvalid, s1_if.rvalid} !== 3'b000) begin bad++; $display("FAIL rst_r_handshake got %b want 000", {m_if.rready, s0_if.rvalid, s1_if.rvalid}); end
        total++; if (dut.r_starve !== 8'd0) begin bad++; $display("FAIL rst_starve got %0d want 0", dut.r_starve); end
        @(negedge clk);
        s0_if.arvalid = 1'b0; s1_if.arvalid = 1'b0; m_if.rvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int w; bit seen; bit to;
        issue(1'b1, 16'h0100, 4'h5, 8'd3, w);
        total++; if (w !== 0) begin bad++; $display("FAIL single_arready_wait got %0d want 0", w); end
        #1;
        total++; if (s1_if.arready !== 1'b0) begin bad++; $display("FAIL single_arready_pulse got %b want 0", s1_if.arready); end
        total++; if ({m_if.arvalid, m_if.araddr, m_if.arid, m_if.arlen} !== {1'b1, 16'h0100, 4'h5, 8'd3}) begin
            bad++; $display("FAIL single_m_ar got %h want %h", {m_if.arvalid, m_if.araddr, m_if.arid, m_if.arlen}, {1'b1, 16'h0100, 4'h5, 8'd3});
        end
        total++; if ({busy, grant} !== 2'b11) begin bad++; $display("FAIL single_busy_grant got %b want 11", {busy, grant}); end
        mem_ar_accept(seen);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL single_ar_accept got %b want 1", seen); end
        mem_burst(1'b1, 4, 16'hA000, 4'h5, -1, 1'b0, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL single_timeout got %b want 0", to); end
        total++; if (q_data.size() !== 4) begin bad++; $display("FAIL single_beats got %0d want 4", q_data.size()); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= q_data.size() || q_data[i] !== 16'hA000 + 16'(i)) begin
                bad++; $display("FAIL single_data%0d got %h want %h", i, (i < q_data.size()) ? q_data[i] : 16'hxxxx, 16'hA000 + 16'(i));
            end
        end
        total++; if (q_last.size() != 4 || q_last[3] !== 1'b1 || q_id[3] !== 4'h5) begin bad++; $display("FAIL single_last_id got size %0d", q_last.size()); end
        total++; if (stray_bad !== 0) begin bad++; $display("FAIL single_s0_rvalid got %0d stray want 0", stray_bad); end
        total++; if (mirror_bad !== 0) begin bad++; $display("FAIL single_rready_mirror got %0d want 0", mirror_bad); end
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_drop got %b want 0", busy); end
    endtask

    task automatic test_starvation();
        int g = 0; int cyc = 0; int c = 0;
        int order[10];
        int sv[10];
        int exp_o[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int exp_s[10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
        s0_if.araddr = 16'h0000; s0_if.arid = 4'h1; s0_if.arlen = 8'd0;
        s1_if.araddr = 16'h1000; s1_if.arid = 4'h2; s1_if.arlen = 8'd0;
        s0_if.arvalid = 1'b1; s1_if.arvalid = 1'b1;
        s0_if.rready = 1'b1; s1_if.rready = 1'b1;
        m_if.arready = 1'b1; m_if.rvalid = 1'b1; m_if.rlast = 1'b1; m_if.rdata = 16'h0;
        while (g < 10 && cyc < 100) begin
            #1;
            if (s0_if.arready) begin order[g] = 0; sv[g] = int'(dut.r_starve); g++; end
            else if (s1_if.arready) begin order[g] = 1; sv[g] = int'(dut.r_starve); g++; end
            @(negedge clk);
            cyc++;
        end
        s0_if.arvalid = 1'b0; s1_if.arvalid = 1'b0;
        #1;
        total++; if (g !== 10) begin bad++; $display("FAIL starve_grants got %0d want 10", g); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (i >= g || order[i] !== exp_o[i] || sv[i] !== exp_s[i]) begin
                bad++; $display("FAIL starve_grant%0d got gnt=%0d starve=%0d want gnt=%0d starve=%0d", i, order[i], sv[i], exp_o[i], exp_s[i]);
            end
        end
        total++; if (dut.r_starve !== 8'd0) begin bad++; $display("FAIL starve_clear got %0d want 0", dut.r_starve); end
        while (busy !== 1'b0 && c < 20) begin @(negedge clk); #1; c++; end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL starve_drain got busy=%b want 0", busy); end
        @(negedge clk);
        m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int w; bit seen; bit to;
        issue(1'b0, 16'h2000, 4'h3, 8'd7, w);
        total++; if (w !== 0) begin bad++; $display("FAIL bp_arready_wait got %0d want 0", w); end
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if ({m_if.arvalid, m_if.araddr, m_if.arlen, m_if.arid} !== {1'b1, 16'h2000, 8'd7, 4'h3}) begin
                bad++; $display("FAIL bp_ar_stable%0d got %h want %h", i, {m_if.arvalid, m_if.araddr, m_if.arlen, m_if.arid}, {1'b1, 16'h2000, 8'd7, 4'h3});
            end
            @(negedge clk);
        end
        mem_ar_accept(seen);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL bp_ar_accept got %b want 1", seen); end
        mem_burst(1'b0, 8, 16'hB000, 4'h3, -1, 1'b1, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL bp_timeout got %b want 0", to); end
        total++; if (q_data.size() !== 8) begin bad++; $display("FAIL bp_beats got %0d want 8", q_data.size()); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (i >= q_data.size() || q_data[i] !== 16'hB000 + 16'(i)) begin
                bad++; $display("FAIL bp_data%0d got %h want %h", i, (i < q_data.size()) ? q_data[i] : 16'hxxxx, 16'hB000 + 16'(i));
            end
        end
        total++; if (mirror_bad !== 0) begin bad++; $display("FAIL bp_rready_mirror got %0d want 0", mirror_bad); end
        total++; if (stray_bad !== 0) begin bad++; $display("FAIL bp_s1_rvalid got %0d want 0", stray_bad); end
    endtask

    task automatic test_stray();
        int w; bit seen;
        m_if.rvalid = 1'b1; m_if.rdata = 16'h5A5A; m_if.rlast = 1'b1; m_if.rresp = 2'b00; m_if.rid = 4'h1;
        s0_if.rready = 1'b1; s1_if.rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({m_if.rready, s0_if.rvalid, s1_if.rvalid} !== 3'b000) begin
                bad++; $display("FAIL stray_idle%0d got %b want 000", i, {m_if.rready, s0_if.rvalid, s1_if.rvalid});
            end
            @(negedge clk);
        end
        issue(1'b0, 16'h3000, 4'h1, 8'd0, w);
        total++; if (w !== 0) begin bad++; $display("FAIL stray_arready_wait got %0d want 0", w); end
        #1;
        total++; if ({m_if.rready, s0_if.rvalid} !== 2'b00) begin bad++; $display("FAIL stray_addr got %b want 00", {m_if.rready, s0_if.rvalid}); end
        mem_ar_accept(seen);
        #1;
        total++; if ({s0_if.rvalid, m_if.rready, s0_if.rdata} !== {2'b11, 16'h5A5A}) begin
            bad++; $display("FAIL stray_deliver got %h want %h", {s0_if.rvalid, m_if.rready, s0_if.rdata}, {2'b11, 16'h5A5A});
        end
        @(negedge clk);
        m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stray_done got busy=%b want 0", busy); end
        @(negedge clk);
    endtask

    task automatic test_error();
        int w; bit seen; bit to;
        issue(1'b1, 16'h0400, 4'h9, 8'd3, w);
        mem_ar_accept(seen);
        total++; if ({w == 0, seen} !== 2'b11) begin bad++; $display("FAIL err_ar got wait=%0d seen=%b want 0,1", w, seen); end
        mem_burst(1'b1, 4, 16'hC000, 4'h9, 2, 1'b0, to);
        total++; if ({to, q_resp.size() == 4} !== 2'b01) begin bad++; $display("FAIL err_beats got to=%b n=%0d want 0,4", to, q_resp.size()); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= q_resp.size() || q_resp[i] !== ((i == 2) ? 2'b10 : 2'b00)) begin
                bad++; $display("FAIL err_rresp%0d got %b want %b", i, (i < q_resp.size()) ? q_resp[i] : 2'bxx, (i == 2) ? 2'b10 : 2'b00);
            end
        end
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL err_idle got busy=%b want 0", busy); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int w; bit seen; bit to;
        s1_if.araddr = 16'h0800; s1_if.arid = 4'h6; s1_if.arlen = 8'd0; s1_if.arvalid = 1'b1;
        issue(1'b0, 16'h3100, 4'h4, 8'd3, w);
        s1_if.arvalid = 1'b0;
        mem_ar_accept(seen);
        total++; if ({w == 0, seen, grant} !== 3'b110) begin bad++; $display("FAIL rmid_ar got wait=%0d seen=%b grant=%b want 0,1,0", w, seen, grant); end
        s0_if.rready = 1'b1; m_if.rvalid = 1'b1; m_if.rlast = 1'b0; m_if.rdata = 16'h3000;
        @(negedge clk);
        m_if.rdata = 16'h3001;
        @(negedge clk);
        #1;
        total++; if ({busy, dut.r_starve} !== {1'b1, 8'd1}) begin bad++; $display("FAIL rmid_pre got busy=%b starve=%0d want 1,1", busy, dut.r_starve); end
        rst = 1'b1; s0_if.arvalid = 1'b1;
        #1;
        total++; if ({busy, m_if.arvalid, m_if.rready, s0_if.rvalid, s0_if.arready} !== 5'b00000) begin
            bad++; $display("FAIL rmid_async got %b want 00000", {busy, m_if.arvalid, m_if.rready, s0_if.rvalid, s0_if.arready});
        end
        total++; if (dut.r_starve !== 8'd0) begin bad++; $display("FAIL rmid_starve got %0d want 0", dut.r_starve); end
        @(negedge clk);
        s0_if.arvalid = 1'b0; m_if.rvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        issue(1'b0, 16'h4000, 4'h7, 8'd0, w);
        #1;
        total++; if ({w == 0, grant, m_if.arvalid, m_if.araddr} !== {1'b1, 1'b0, 1'b1, 16'h4000}) begin
            bad++; $display("FAIL rmid_regrant got wait=%0d grant=%b arvalid=%b addr=%h", w, grant, m_if.arvalid, m_if.araddr);
        end
        mem_ar_accept(seen);
        mem_burst(1'b0, 1, 16'h4444, 4'h7, -1, 1'b0, to);
        total++; if ({to, q_data.size() == 1} !== 2'b01 || q_data[0] !== 16'h4444) begin bad++; $display("FAIL rmid_burst got to=%b n=%0d", to, q_data.size()); end
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_idle got busy=%b want 0", busy); end
    endtask

    initial begin
        rst = 1'b1;
        s0_if.arvalid = 1'b0; s0_if.araddr = '0; s0_if.arid = '0; s0_if.arlen = '0;
        s0_if.arsize = '0; s0_if.arburst = '0; s0_if.rready = 1'b0;
        s1_if.arvalid = 1'b0; s1_if.araddr = '0; s1_if.arid = '0; s1_if.arlen = '0;
        s1_if.arsize = '0; s1_if.arburst = '0; s1_if.rready = 1'b0;
        m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rdata = '0; m_if.rid = '0;
        m_if.rresp = 2'b00; m_if.rlast = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_starvation();
        test_backpressure();
        test_stray();
        test_error();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
